mk_network: RTL and testbench
=============================

# mk_network

Nine-endpoint packet network that moves single-flit packets between compute nodes N0..N8. Each node injects 71-bit flits on its send port, and the network delivers each flit to the receive port named by its destination field. It provides per-VC credit flow control toward senders and runs on a single clock. It is the interconnect between the operator nodes of the mapping testbenches.

## Interface
- Parameters: none. Fixed: 9 ports; flit 71 bits; 2 VCs; input FIFO depth 4 per VC.
- Flit layout: [70] valid, [69] tail (carried, unused), [68:65] dest, [64] vc, [63:0] data.
- Credit layout: [1] valid, [0] vc.
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  reset, synchronous, active-high (name kept from codebase convention).
- send_ports_i_putFlit_flit_in  in  71  injected flit, i=0..8.
- EN_send_ports_i_putFlit  in  1  enqueue strobe; the flit is considered only when this is 1 and flit[70]=1.
- send_ports_i_getCredits  out  2  credit return to sender i.
- EN_send_ports_i_getCredits  in  1  acknowledge; ignored, credits are not held.
- recv_ports_i_getFlit  out  71  delivered flit; all zero when idle.
- EN_recv_ports_i_getFlit  in  1  consume strobe; ignored, receivers are always ready.
- recv_ports_i_putCredits_cr_in  in  2  reserved; ignored.
- EN_recv_ports_i_putCredits  in  1  reserved; ignored.

## Operation
- Input side: each send port has two 4-entry FIFOs, one per VC. The vc bit selects the FIFO.
  - Enqueue succeeds if count<4, or if that FIFO is dequeued in the same cycle.
  - Otherwise the flit is dropped silently; this is a sender credit violation.
- Destination check: a flit with dest>=9 is discarded at enqueue. A credit {1,vc} is still returned on the next cycle.
- VC select: each input presents one head flit per cycle.
  - If only one VC FIFO is nonempty, that VC is presented.
  - If both are nonempty, a per-input 1-bit pointer chooses (reset value VC0). The pointer toggles only when the presented flit wins.
- Output arbitration: each output d has a round-robin arbiter over inputs 0..8 whose presented head has dest==d.
  - Reset priority is input 0.
  - After a grant, priority moves to the winner+1 (mod 9).
- At most one grant per output and one per input per cycle. Losers keep their heads and retry.
- On a grant:
  - The winner's head is dequeued.
  - The flit is copied unchanged into recv register d, including vc, tail and dest.
  - send_ports_winner_getCredits = {1, vc} in the following cycle.
- recv register d holds the flit for exactly one cycle. It returns to 0 when there is no grant.
- No receive-side flow control; every granted flit is delivered.
- Holding EN=1 with the same valid flit injects a new copy every cycle.

## Timing
- Zero-load latency is 2 edges:
  - Flit presented before edge k is enqueued at edge k.
  - It is granted at edge k+1.
  - It is visible on recv_ports_d_getFlit during cycle k+1..k+2.
  - The matching credit is visible on send_ports_i_getCredits in the same cycle.
- Throughput: 1 flit/cycle per output and per input.
- Reset (RST_N=1 at an edge):
  - Clears all FIFOs, VC pointers and RR pointers.
  - All getFlit outputs and all getCredits outputs become 0 after that edge.
  - Flits in flight are lost and no credits are issued for them.
- While RST_N=1, putFlit is ignored.
- Simultaneous events:
  - Enqueue and dequeue on the same FIFO in one cycle keeps the count unchanged.
  - The same-cycle enqueue path never bypasses the FIFO, so the minimum latency stays 2.

## Test plan
- Single flit: port 4 sends {1,1,4'd4,0,64'd13} for one cycle → recv_ports_4 = same 71 bits exactly 2 edges later, for one cycle; send_ports_4_getCredits = 2'b10 the same cycle.
- Contention: ports 0 and 1 send to dest 6 in the same cycle (data 40 and 45) after reset → recv 6 delivers 40, then 45 on the next cycle; a repeat then favours port 1 first only if the RR pointer points there (pointer=2 → port 0 first again).
- VC interleave: port 3 queues two VC0 and two VC1 flits to dest 5 → delivery order VC0,VC1,VC0,VC1; credits {1,0},{1,1},{1,0},{1,1}.
- Overflow: ports 0,1,2 hold valid flits to dest 7 on VC0 every cycle for 20 cycles → recv 7 delivers one per cycle round-robin 0,1,2; excess flits dropped; no FIFO ever exceeds 4.
- Bad destination: port 2 sends dest 4'd12 → no recv output anywhere; credit 2'b10 on port 2 the next cycle.
- Reset mid-traffic: assert RST_N for one edge with 3 flits queued → all outputs 0 the next cycle; no stale flit emerges afterwards.

Source files
------------

// File: rtl/mk_network_if.sv
// Bundle of the nine send/receive endpoint ports of mk_network.
// master = compute nodes, slave = the network itself.
interface mk_network_if;
    logic [8:0][70:0] send_ports_putFlit_flit_in;
    logic [8:0]       EN_send_ports_putFlit;
    logic [8:0][1:0]  send_ports_getCredits;
    logic [8:0]       EN_send_ports_getCredits;
    logic [8:0][70:0] recv_ports_getFlit;
    logic [8:0]       EN_recv_ports_getFlit;
    logic [8:0][1:0]  recv_ports_putCredits_cr_in;
    logic [8:0]       EN_recv_ports_putCredits;

    modport master (
        output send_ports_putFlit_flit_in,
        output EN_send_ports_putFlit,
        input  send_ports_getCredits,
        output EN_send_ports_getCredits,
        input  recv_ports_getFlit,
        output EN_recv_ports_getFlit,
        output recv_ports_putCredits_cr_in,
        output EN_recv_ports_putCredits
    );

    modport slave (
        input  send_ports_putFlit_flit_in,
        input  EN_send_ports_putFlit,
        output send_ports_getCredits,
        input  EN_send_ports_getCredits,
        output recv_ports_getFlit,
        input  EN_recv_ports_getFlit,
        input  recv_ports_putCredits_cr_in,
        input  EN_recv_ports_putCredits
    );
endinterface

// File: rtl/mk_network.sv
// Nine-port single-flit crossbar: per-input two-VC FIFOs, per-output round-robin
// arbitration, registered delivery and credit return one edge after the grant.
module mk_network (
    input logic         CLK,
    input logic         RST_N,
    mk_network_if.slave net
);
    localparam int NP    = 9;
    localparam int NV    = 2;
    localparam int DEPTH = 4;
    localparam int FW    = 71;

    logic [FW-1:0]                 mem_q [NP][NV][DEPTH];
    logic [NP-1:0][NV-1:0][1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [NP-1:0][NV-1:0][2:0]    cnt_q, cnt_d;
    logic [NP-1:0][NV-1:0]         we;
    logic [NP-1:0]                 vcp_q, vcp_d;
    logic [NP-1:0][3:0]            rr_q, rr_d;
    logic [NP-1:0][FW-1:0]         recv_q, recv_d;
    logic [NP-1:0][1:0]            cred_q, cred_d;

    logic [NP-1:0]                 sel_vc;
    logic [NP-1:0]                 pres_vld;
    logic [NP-1:0][FW-1:0]         pres_flit;
    logic [NP-1:0]                 gnt_in;

    logic unused_ok;
    assign unused_ok = ^{net.EN_send_ports_getCredits, net.EN_recv_ports_getFlit,
                         net.recv_ports_putCredits_cr_in, net.EN_recv_ports_putCredits};

    // Each input offers one head; the VC pointer only matters when both VCs hold flits.
    always_comb begin
        sel_vc    = '0;
        pres_vld  = '0;
        pres_flit = '0;
        for (int i = 0; i < NP; i++) begin
            if (cnt_q[i][0] != 3'd0 && cnt_q[i][1] != 3'd0) begin
                sel_vc[i] = vcp_q[i];
            end else begin
                sel_vc[i] = (cnt_q[i][1] != 3'd0);
            end
            pres_vld[i]  = (cnt_q[i][0] != 3'd0) || (cnt_q[i][1] != 3'd0);
            pres_flit[i] = mem_q[i][sel_vc[i]][rd_q[i][sel_vc[i]]];
        end
    end

    // An input presents a single destination, so one grant per input falls out naturally.
    always_comb begin
        int  idx;
        logic found;
        gnt_in = '0;
        rr_d   = rr_q;
        recv_d = '0;
        idx    = 0;
        found  = 1'b0;
        for (int d = 0; d < NP; d++) begin
            found = 1'b0;
            for (int k = 0; k < NP; k++) begin
                idx = int'(rr_q[d]) + k;
                if (idx >= NP) idx = idx - NP;
                if (!found && pres_vld[idx] && pres_flit[idx][68:65] == 4'(d)) begin
                    found       = 1'b1;
                    gnt_in[idx] = 1'b1;
                    recv_d[d]   = pres_flit[idx];
                    rr_d[d]     = (idx == NP - 1) ? 4'd0 : 4'(idx + 1);
                end
            end
        end
    end

    always_comb begin
        logic [FW-1:0] in_f;
        logic          in_v;
        logic          bad;
        logic          deq;
        logic          enq;
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        vcp_d  = vcp_q;
        cred_d = '0;
        we     = '0;
        in_f   = '0;
        in_v   = 1'b0;
        bad    = 1'b0;
        deq    = 1'b0;
        enq    = 1'b0;
        for (int i = 0; i < NP; i++) begin
            in_f = net.send_ports_putFlit_flit_in[i];
            in_v = net.EN_send_ports_putFlit[i] && in_f[70];
            bad  = in_f[68:65] >= 4'd9;
            for (int v = 0; v < NV; v++) begin
                deq = gnt_in[i] && (sel_vc[i] == 1'(v));
                enq = in_v && !bad && (in_f[64] == 1'(v)) && (cnt_q[i][v] != 3'(DEPTH) || deq);
                if (deq) rd_d[i][v] = rd_q[i][v] + 2'd1;
                if (enq) wr_d[i][v] = wr_q[i][v] + 2'd1;
                we[i][v] = enq;
                case ({enq, deq})
                    2'b10:   cnt_d[i][v] = cnt_q[i][v] + 3'd1;
                    2'b01:   cnt_d[i][v] = cnt_q[i][v] - 3'd1;
                    default: cnt_d[i][v] = cnt_q[i][v];
                endcase
            end
            if (gnt_in[i]) begin
                cred_d[i] = {1'b1, sel_vc[i]};
                vcp_d[i]  = ~vcp_q[i];
            end else if (in_v && bad) begin
                cred_d[i] = {1'b1, in_f[64]};
            end
        end
    end

    // Flit storage carries no reset; validity lives entirely in the counters.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NP; i++) begin
            for (int v = 0; v < NV; v++) begin
                if (we[i][v]) mem_q[i][v][wr_q[i][v]] <= net.send_ports_putFlit_flit_in[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_N) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            vcp_q  <= '0;
            rr_q   <= '0;
            recv_q <= '0;
            cred_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            vcp_q  <= vcp_d;
            rr_q   <= rr_d;
            recv_q <= recv_d;
            cred_q <= cred_d;
        end
    end

    assign net.recv_ports_getFlit    = recv_q;
    assign net.send_ports_getCredits = cred_q;
endmodule

// File: tb/tb_mk_network.sv
// Directed and randomized check of mk_network against a queue-based packet model.
module tb_mk_network;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mk_network_if nif();

    mk_network dut (
        .CLK   (clk),
        .RST_N (rst),
        .net   (nif)
    );

    always #5 clk = ~clk;

    // Reference state: one packet queue per (input, VC), plus the two pointer sets.
    logic [70:0] mq [18][$];
    bit          vptr [9];
    int          rr   [9];
    logic [70:0] exp_recv [9];
    logic [1:0]  exp_cred [9];

    function automatic logic [70:0] mkf(int dest, bit vc, logic [63:0] data);
        return {1'b1, 1'b1, 4'(dest), vc, data};
    endfunction

    task automatic chk(string tag, logic [70:0] obs, logic [70:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        nif.send_ports_putFlit_flit_in = '0;
        nif.EN_send_ports_putFlit      = '0;
    endtask

    task automatic put(int p, logic [70:0] f);
        nif.send_ports_putFlit_flit_in[p] = f;
        nif.EN_send_ports_putFlit[p]      = 1'b1;
    endtask

    task automatic model_edge();
        int pv [9];
        int pdest [9];
        logic [70:0] f;
        for (int i = 0; i < 9; i++) begin
            exp_recv[i] = '0;
            exp_cred[i] = '0;
        end
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                mq[2*i].delete();
                mq[2*i+1].delete();
                vptr[i] = 0;
                rr[i]   = 0;
            end
            return;
        end
        for (int i = 0; i < 9; i++) begin
            pv[i] = -1;
            pdest[i] = -1;
            if (mq[2*i].size() > 0 && mq[2*i+1].size() > 0) pv[i] = int'(vptr[i]);
            else if (mq[2*i].size() > 0) pv[i] = 0;
            else if (mq[2*i+1].size() > 0) pv[i] = 1;
            if (pv[i] >= 0) pdest[i] = int'(mq[2*i+pv[i]][0][68:65]);
        end
        for (int d = 0; d < 9; d++) begin
            bit got = 0;
            for (int k = 0; k < 9; k++) begin
                int i = (rr[d] + k) % 9;
                if (!got && pdest[i] == d) begin
                    got = 1;
                    f = mq[2*i+pv[i]].pop_front();
                    exp_recv[d] = f;
                    exp_cred[i] = {1'b1, f[64]};
                    rr[d] = (i + 1) % 9;
                    vptr[i] = ~vptr[i];
                end
            end
        end
        for (int i = 0; i < 9; i++) begin
            f = nif.send_ports_putFlit_flit_in[i];
            if (nif.EN_send_ports_putFlit[i] && f[70]) begin
                if (f[68:65] >= 4'd9) begin
                    if (exp_cred[i] == 2'b00) exp_cred[i] = {1'b1, f[64]};
                end else if (mq[2*i+int'(f[64])].size() < 4) begin
                    mq[2*i+int'(f[64])].push_back(f);
                end
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        for (int d = 0; d < 9; d++)
            chk($sformatf("recv%0d", d), nif.recv_ports_getFlit[d], exp_recv[d]);
        for (int i = 0; i < 9; i++)
            chk($sformatf("cred%0d", i), 71'(nif.send_ports_getCredits[i]), 71'(exp_cred[i]));
    endtask

    initial begin
        logic [70:0] f;
        clear_in();
        nif.EN_send_ports_getCredits    = '1;
        nif.EN_recv_ports_getFlit       = '1;
        nif.recv_ports_putCredits_cr_in = '0;
        nif.EN_recv_ports_putCredits    = '0;

        // Reset state, with a flit offered during reset that must be ignored.
        put(0, mkf(1, 0, 64'd99));
        step();
        clear_in();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) step();

        // Single flit, two edges of latency.
        f = {1'b1, 1'b1, 4'd4, 1'b0, 64'd13};
        put(4, f);
        step();
        clear_in();
        chk("single_early", nif.recv_ports_getFlit[4], 71'd0);
        step();
        chk("single_recv4", nif.recv_ports_getFlit[4], f);
        chk("single_cred4", 71'(nif.send_ports_getCredits[4]), 71'(2'b10));
        step();
        chk("single_gone", nif.recv_ports_getFlit[4], 71'd0);

        // Contention on dest 6, repeated: pointer lands on 2, so port 0 wins again.
        for (int r = 0; r < 2; r++) begin
            put(0, mkf(6, 0, 64'd40));
            put(1, mkf(6, 0, 64'd45));
            step();
            clear_in();
            step();
            chk("cont_first", 71'(nif.recv_ports_getFlit[6][63:0]), 71'd40);
            step();
            chk("cont_second", 71'(nif.recv_ports_getFlit[6][63:0]), 71'd45);
            step();
        end

        // VC interleave from port 3 to dest 5.
        for (int k = 0; k < 4; k++) begin
            clear_in();
            put(3, mkf(5, k[0], 64'(100 + k)));
            step();
            if (k > 0) chk("vc_cred", 71'(nif.send_ports_getCredits[3]), 71'({1'b1, ~k[0]}));
        end
        clear_in();
        for (int c = 0; c < 3; c++) step();

        // Overflow: three ports hammer dest 7 on VC0.
        for (int c = 0; c < 20; c++) begin
            for (int p = 0; p < 3; p++) put(p, mkf(7, 0, 64'(1000 * p + c)));
            step();
        end
        clear_in();
        for (int c = 0; c < 16; c++) step();

        // Bad destination: discarded, credit still returned.
        put(2, mkf(12, 0, 64'd7));
        step();
        clear_in();
        chk("bad_cred2", 71'(nif.send_ports_getCredits[2]), 71'(2'b10));
        step();

        // Reset with three flits queued.
        for (int p = 0; p < 3; p++) put(p, mkf(8, 1, 64'(500 + p)));
        step();
        clear_in();
        rst = 1'b1;
        step();
        chk("rst_recv8", nif.recv_ports_getFlit[8], 71'd0);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) step();

        // Randomized traffic with skewed destinations and occasional resets.
        for (int c = 0; c < 400; c++) begin
            clear_in();
            rst = ($urandom_range(0, 99) == 0);
            for (int p = 0; p < 9; p++) begin
                if ($urandom_range(0, 9) < 4) begin
                    int d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                                        : int'($urandom_range(0, 2));
                    nif.send_ports_putFlit_flit_in[p] =
                        {1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 4'(d),
                         1'($urandom_range(0, 1)), $urandom, $urandom};
                    nif.EN_send_ports_putFlit[p] = 1'b1;
                end
            end
            step();
        end
        clear_in();
        rst = 1'b0;
        for (int c = 0; c < 40; c++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
